// File: rtl/lif_ctrl_pkg.sv
// Shared definitions for the LIF neuron update scheduler: controller
// states and default sizing.
package lif_ctrl_pkg;

  localparam int NUM_NEURONS_DEF = 3;
  localparam int DATA_W_DEF      = 8;

  // Load phases come first (IDLE captures threshold), then the run phases.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_DEC = 3'd1,
    LD_REF = 3'd2,
    READY  = 3'd3,
    RUN    = 3'd4
  } lif_state_e;

  // True for the states in which a config word is accepted.
  function automatic logic is_load_state(input lif_state_e st);
    logic res;
    case (st)
      IDLE, LD_DEC, LD_REF: res = 1'b1;
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lif_slot_counter.sv
// Time-multiplexing slot counter: steps through the neuron slots while
// enabled, wraps after the last one and decodes the slot to one-hot.
module lif_slot_counter
  import lif_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   enable,
  output logic [1:0]             slot_idx,
  output logic                   last_slot,
  output logic [NUM_NEURONS-1:0] slot_onehot
);

  localparam logic [1:0] LAST_SLOT = 2'(NUM_NEURONS - 1);

  logic [1:0] slot_r;

  // Slot register: clear wins over advance; wraps on the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= 2'd0;
    end else if (clear) begin
      slot_r <= 2'd0;
    end else if (enable) begin
      if (slot_r == LAST_SLOT) begin
        slot_r <= 2'd0;
      end else begin
        slot_r <= slot_r + 2'd1;
      end
    end
  end

  // One-hot decode of the current slot.
  always_comb begin
    slot_onehot = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (slot_r == 2'(i)) begin
        slot_onehot[i] = 1'b1;
      end else begin
        slot_onehot[i] = 1'b0;
      end
    end
  end

  assign slot_idx  = slot_r;
  assign last_slot = (slot_r == LAST_SLOT);

endmodule

// File: rtl/lif_neuron_scheduler.sv
// LIF neuron scheduler: loads threshold/decay/refractory parameters over a
// shared config handshake, then issues one-hot update enables across the
// neuron slots in frames while run_req is held, counting completed frames.
module lif_neuron_scheduler
  import lif_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  input  logic [DATA_W-1:0]      cfg_data,
  output logic                   cfg_ready,
  input  logic                   run_req,
  input  logic                   halt,
  output logic [DATA_W-1:0]      threshold,
  output logic [DATA_W-1:0]      decay,
  output logic [DATA_W-1:0]      refractory_period,
  output logic                   cfg_loaded,
  output logic [NUM_NEURONS-1:0] neuron_en,
  output logic [1:0]             slot_idx,
  output logic                   frame_done,
  output logic [15:0]            step_count
);

  lif_state_e state_r, state_next_s;

  logic [DATA_W-1:0]      threshold_r, decay_r, refractory_r;
  logic                   cfg_loaded_r;
  logic [15:0]            step_count_r;
  logic                   last_slot_s;
  logic [NUM_NEURONS-1:0] slot_onehot_s;
  logic                   in_run_s;
  logic                   cfg_take_s;

  assign in_run_s   = (state_r == RUN);
  // A coincident halt discards the handshake.
  assign cfg_take_s = cfg_valid && cfg_ready && !halt;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; halt overrides everything, frames always complete.
  always_comb begin
    state_next_s = state_r;
    if (halt) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_valid) state_next_s = LD_DEC;
          else           state_next_s = IDLE;
        end
        LD_DEC: begin
          if (cfg_valid) state_next_s = LD_REF;
          else           state_next_s = LD_DEC;
        end
        LD_REF: begin
          if (cfg_valid) state_next_s = READY;
          else           state_next_s = LD_REF;
        end
        READY: begin
          if (run_req) state_next_s = RUN;
          else         state_next_s = READY;
        end
        RUN: begin
          if (last_slot_s) begin
            if (run_req) state_next_s = RUN;
            else         state_next_s = READY;
          end else begin
            state_next_s = RUN;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Config acceptance depends on the state alone.
  always_comb begin
    cfg_ready = 1'b0;
    if (is_load_state(state_r)) begin
      cfg_ready = 1'b1;
    end else begin
      cfg_ready = 1'b0;
    end
  end

  // Parameter capture in load order; values survive halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold_r  <= '0;
      decay_r      <= '0;
      refractory_r <= '0;
    end else if (cfg_take_s) begin
      case (state_r)
        IDLE:    threshold_r  <= cfg_data;
        LD_DEC:  decay_r      <= cfg_data;
        LD_REF:  refractory_r <= cfg_data;
        default: threshold_r  <= threshold_r;
      endcase
    end
  end

  // Loaded flag: set with the last parameter, dropped by halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_loaded_r <= 1'b0;
    end else if (halt) begin
      cfg_loaded_r <= 1'b0;
    end else if (cfg_take_s && (state_r == LD_REF)) begin
      cfg_loaded_r <= 1'b1;
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits; kept over halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count_r <= 16'd0;
    end else if (!halt && in_run_s && last_slot_s) begin
      step_count_r <= step_count_r + 16'd1;
    end
  end

  lif_slot_counter #(
    .NUM_NEURONS (NUM_NEURONS)
  ) u_slot_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (halt),
    .enable      (in_run_s),
    .slot_idx    (slot_idx),
    .last_slot   (last_slot_s),
    .slot_onehot (slot_onehot_s)
  );

  assign neuron_en         = in_run_s ? slot_onehot_s : '0;
  assign frame_done        = in_run_s && last_slot_s;
  assign threshold         = threshold_r;
  assign decay             = decay_r;
  assign refractory_period = refractory_r;
  assign cfg_loaded        = cfg_loaded_r;
  assign step_count        = step_count_r;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Scoreboard bench for lif_neuron_scheduler: a driver steps a behavioural
// model each cycle and queues the expected post-edge outputs; a monitor
// pops and compares after every rising edge.
module tb_lif_neuron_scheduler;

  localparam int N  = 3;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic [DW-1:0] cfg_data;
  logic          cfg_ready;
  logic          run_req;
  logic          halt;
  logic [DW-1:0] threshold, decay, refractory_period;
  logic          cfg_loaded;
  logic [N-1:0]  neuron_en;
  logic [1:0]    slot_idx;
  logic          frame_done;
  logic [15:0]   step_count;

  lif_neuron_scheduler #(.NUM_NEURONS(N), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_valid         (cfg_valid),
    .cfg_data          (cfg_data),
    .cfg_ready         (cfg_ready),
    .run_req           (run_req),
    .halt              (halt),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .cfg_loaded        (cfg_loaded),
    .neuron_en         (neuron_en),
    .slot_idx          (slot_idx),
    .frame_done        (frame_done),
    .step_count        (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          cr;
    logic [DW-1:0] th, de, rf;
    logic          ld;
    logic [N-1:0]  en;
    logic [1:0]    sl;
    logic          fd;
    logic [15:0]   sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: mode 0/1/2 = waiting for word 0/1/2, 3 = ready,
  // 4 = running frames.
  int            m_mode;
  logic [DW-1:0] m_par[3];
  bit            m_loaded;
  int            m_slot;
  int            m_steps;

  function automatic void model_reset();
    m_mode = 0; m_loaded = 0; m_slot = 0; m_steps = 0;
    for (int i = 0; i < 3; i++) m_par[i] = '0;
  endfunction

  function automatic void model_step(bit cv, logic [DW-1:0] cd, bit rr, bit h);
    if (h) begin
      m_mode = 0; m_loaded = 0; m_slot = 0;
    end else if (m_mode < 3) begin
      if (cv) begin
        m_par[m_mode] = cd;
        m_mode++;
        if (m_mode == 3) m_loaded = 1;
      end
    end else if (m_mode == 3) begin
      if (rr) begin m_mode = 4; m_slot = 0; end
    end else begin
      if (m_slot == N - 1) begin
        m_steps = (m_steps + 1) % 65536;
        m_slot  = 0;
        m_mode  = rr ? 4 : 3;
      end else begin
        m_slot++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.cr = (m_mode < 3);
    e.th = m_par[0];
    e.de = m_par[1];
    e.rf = m_par[2];
    e.ld = m_loaded;
    e.en = (m_mode == 4) ? N'(1 << m_slot) : '0;
    e.sl = 2'(m_slot);
    e.fd = (m_mode == 4) && (m_slot == N - 1);
    e.sc = 16'(m_steps);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cfg_ready",  32'(cfg_ready),         32'(e.cr));
        chk("threshold",  32'(threshold),         32'(e.th));
        chk("decay",      32'(decay),             32'(e.de));
        chk("refractory", 32'(refractory_period), 32'(e.rf));
        chk("cfg_loaded", 32'(cfg_loaded),        32'(e.ld));
        chk("neuron_en",  32'(neuron_en),         32'(e.en));
        chk("slot_idx",   32'(slot_idx),          32'(e.sl));
        chk("frame_done", 32'(frame_done),        32'(e.fd));
        chk("step_count", 32'(step_count),        32'(e.sc));
      end
    end
  end

  // One cycle of stimulus, called at a falling edge; returns at the next.
  task automatic cyc(input bit cv, input logic [DW-1:0] cd, input bit rr, input bit h);
    cfg_valid = cv; cfg_data = cd; run_req = rr; halt = h;
    if (!rst_n) model_reset();
    else        model_step(cv, cd, rr, h);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic load3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    cyc(1, a, 0, 0);
    cyc(1, b, 0, 0);
    cyc(1, c, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_neuron_en"},  32'(neuron_en),  32'd0);
    chk({tag, "_cfg_ready"},  32'(cfg_ready),  32'd1);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_regs"}, 32'({threshold, decay, refractory_period}), 32'd0);
    chk({tag, "_state"}, 32'({cfg_loaded, slot_idx, step_count}), 32'd0);
  endtask

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    int guard;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; run_req = 1'b0; halt = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset_init");
    @(negedge clk);
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // Load with a stall in the middle, then back-to-back words.
    cyc(1, 8'h40, 0, 0);
    cyc(0, 8'h99, 0, 0);
    cyc(1, 8'h05, 0, 0);
    cyc(1, 8'h0A, 0, 0);
    cyc(1, 8'hEE, 0, 0);   // ignored in READY

    // Run with run_req held 7 cycles, then let the frame finish.
    repeat (7) cyc(1, 8'h33, 1, 0);
    guard = 0;
    while (m_mode != 3 && guard < 10) begin cyc(0, 8'h00, 0, 0); guard++; end
    chk("run_to_ready_bound", 32'(m_mode), 32'd3);

    // Drop run_req at slot 1: slot 2 still issued, then READY.
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);

    // Halt from READY, reload threshold, halt coincident with decay word.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h77, 0, 1);
    cyc(0, 8'h00, 0, 0);
    load3(8'h22, 8'h03, 8'h07);

    // Counter wrap: preset to 0xFFFF, run exactly one frame.
    force dut.step_count_r = 16'hFFFF;
    m_steps = 16'hFFFF;
    cyc(0, 8'h00, 0, 0);
    release dut.step_count_r;
    cyc(0, 8'h00, 1, 0);
    repeat (3) cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);

    // Asynchronous reset during slot 1 of a frame.
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    chk("at_slot1_before_reset", 32'(m_slot), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_midrun");
    @(negedge clk);
    cyc(0, 8'h00, 1, 0);
    rst_n = 1'b1;

    // Randomized traffic with occasional halts.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 24) == 0));
    end

    cyc(0, 8'h00, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 5) begin @(negedge clk); guard++; end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_neuron_scheduler.md
LIF_NEURON_SCHEDULER -- requirements
Module: lif_neuron_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 3, the number of time-multiplexed neuron slots (2..4).
REQ-002 SHALL have parameter DATA_W, default 8, the width of the config bus and of each parameter register.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port cfg_valid, input, 1 bit, config word valid.
REQ-006 SHALL have port cfg_data, input, DATA_W bits, the shared config word.
REQ-007 SHALL have port cfg_ready, output, 1 bit, scheduler accepts a config word.
REQ-008 SHALL have port run_req, input, 1 bit, level request to run update frames.
REQ-009 SHALL have port halt, input, 1 bit, synchronous abort to IDLE.
REQ-010 SHALL have ports threshold, decay and refractory_period, outputs, DATA_W bits each, the held neuron parameters.
REQ-011 SHALL have port cfg_loaded, output, 1 bit, all three parameters captured.
REQ-012 SHALL have port neuron_en, output, NUM_NEURONS bits, one-hot update enable.
REQ-013 SHALL have port slot_idx, output, 2 bits, the current slot.
REQ-014 SHALL have port frame_done, output, 1 bit, high on the last slot of a frame.
REQ-015 SHALL have port step_count, output, 16 bits, the completed-frame count.

Function
REQ-016 SHALL implement the FSM states IDLE, LD_DEC, LD_REF, READY and RUN.
REQ-017 SHALL drive cfg_ready = 1 exactly in IDLE, LD_DEC and LD_REF (combinational from state).
REQ-018 SHALL, on a handshake (cfg_valid and cfg_ready at the edge), capture in order: IDLE -> threshold and go to LD_DEC; LD_DEC -> decay and go to LD_REF; LD_REF -> refractory_period, go to READY and set cfg_loaded.
REQ-019 SHALL hold the state and the registers while cfg_valid is low during loading; there is no timeout.
REQ-020 SHALL, in READY, go to RUN at the edge where run_req = 1, with slot_idx = 0.
REQ-021 SHALL, in RUN, drive neuron_en = one-hot(slot_idx); neuron_en is 0 in every other state.
REQ-022 SHALL advance slot_idx by 1 per cycle in RUN, wrapping from NUM_NEURONS-1 to 0.
REQ-023 SHALL drive frame_done = 1 in RUN when slot_idx = NUM_NEURONS-1, and at that edge increment step_count modulo 2^16 (0xFFFF -> 0x0000).
REQ-024 SHALL, when run_req = 0 at the last-slot edge, go to READY; a frame is never truncated by run_req.
REQ-025 SHALL give halt priority over all other inputs: go to IDLE at the next edge, clear cfg_loaded and slot_idx, and discard any coincident handshake.
REQ-026 SHALL, on halt, retain the parameter values and step_count.
REQ-027 SHALL ignore cfg_valid in READY and RUN; parameters are never modified while running.
REQ-028 SHALL reach the first neuron_en[0] pulse one cycle after the run_req sampling edge in READY.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state IDLE and set threshold, decay, refractory_period, slot_idx, step_count and cfg_loaded to 0.
REQ-030 SHALL therefore present cfg_ready = 1, neuron_en = 0 and frame_done = 0 while in reset.
REQ-031 SHALL, on reset asserted mid-load or mid-frame, abandon the partial configuration or frame without further outputs.

Structure
REQ-032 SHALL take the state enum, NUM_NEURONS and DATA_W defaults from shared package lif_ctrl_pkg.
REQ-033 SHALL place the slot counter and one-hot decode in sub-module lif_slot_counter (enable, wrap, last-slot flag).

Verification
REQ-034 SHALL verify load: words 0x40, 0x05, 0x0A with cfg_valid held high -> threshold = 0x40, decay = 0x05, refractory_period = 0x0A, and cfg_loaded high after the 3rd edge.
REQ-035 SHALL verify run: after load, run_req high for 7 cycles -> neuron_en sequence 001, 010, 100, 001, 010, 100, and step_count = 2 after the frame.
REQ-036 SHALL verify stop: run_req dropped mid-frame at slot 1 -> slot 2 still issued with frame_done, then READY with neuron_en = 0.
REQ-037 SHALL verify halt: halt together with cfg_valid in LD_DEC -> IDLE, decay unchanged, cfg_loaded = 0.
REQ-038 SHALL verify wrap: step_count preset to 0xFFFF through 65535 frames -> 0x0000 after the next frame_done.
REQ-039 SHALL verify reset: rst_n low during RUN slot 1 -> neuron_en = 0 immediately, all registers 0, cfg_ready = 1.
